// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC scheduler: word-length helper, scheduler
// state encoding and fixed-point angle constants used with the rotational core.
package cordic_pkg;

  localparam int DEF_INT_LENGTH    = 5;
  localparam int DEF_FRAC_LENGTH   = 12;
  localparam int CORDIC_ITERATIONS = 12;
  localparam int CORE_LATENCY      = CORDIC_ITERATIONS + 1;

  function automatic int cordic_wl(input int int_length, input int frac_length);
    return int_length + frac_length;
  endfunction

  localparam int DEF_WL = cordic_wl(DEF_INT_LENGTH, DEF_FRAC_LENGTH);

  // Angles in the default Q5.12 format (round(angle * 2^12)).
  localparam logic [DEF_WL-1:0] ANGLE_PI     = 17'h03244;
  localparam logic [DEF_WL-1:0] ANGLE_PI_2   = 17'h01922;
  localparam logic [DEF_WL-1:0] ANGLE_TWO_PI = 17'h06488;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    BUSY   = 3'd2,
    RESP   = 3'd3,
    ABORT  = 3'd4
  } cordic_sched_state_t;

endpackage

// File: rtl/cordic_rr_scheduler_arbiter.sv
// Combinational round-robin picker: rotate requests so the slot after last_ptr
// sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_any
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NUM_REQ);

  logic [IW-1:0]        start_s;
  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [IW-1:0]        pos_s;
  logic [IW:0]          sum_s;
  logic [IW:0]          wrap_s;

  // First slot to consider, wrapping past the top requester.
  always_comb begin
    if (last_ptr >= IW'(NUM_REQ - 1)) begin
      start_s = '0;
    end else begin
      start_s = last_ptr + IW'(1);
    end
  end

  assign dbl_s = {req, req};
  assign rot_s = dbl_s[start_s +: NUM_REQ];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    pos_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_s = rot_s[k] ? IW'(k) : pos_s;
    end
  end

  // Undo the rotation, modulo NUM_REQ (which need not be a power of two).
  always_comb begin
    sum_s  = {1'b0, pos_s} + {1'b0, start_s};
    wrap_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
  end

  assign grant_any = |req;
  assign grant_idx = wrap_s[IW-1:0];
  assign grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Round-robin scheduler sharing one rotational CORDIC core between NUM_REQ
// requesters, with a watchdog abort and a tagged valid/ready response port.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  INT_LENGTH  = DEF_INT_LENGTH,
  parameter int  FRAC_LENGTH = DEF_FRAC_LENGTH,
  parameter int  TIMEOUT     = 32,
  localparam int WL          = cordic_wl(INT_LENGTH, FRAC_LENGTH),
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*WL-1:0] req_x,
  input  logic [NUM_REQ*WL-1:0] req_y,
  input  logic [NUM_REQ*WL-1:0] req_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [WL-1:0]         rsp_x,
  output logic [WL-1:0]         rsp_y,
  output logic [WL-1:0]         rsp_z,
  output logic                  rsp_timeout,
  output logic                  core_enable,
  output logic [WL-1:0]         core_xo,
  output logic [WL-1:0]         core_yo,
  output logic [WL-1:0]         core_zo,
  input  logic [WL-1:0]         core_xn,
  input  logic [WL-1:0]         core_yn,
  input  logic [WL-1:0]         core_zn,
  input  logic                  core_done,
  output logic                  core_rst_n
);

  localparam int          CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  cordic_sched_state_t state_r;
  logic [IW-1:0]       last_ptr_r;
  logic [IW-1:0]       id_r;
  logic [CW-1:0]       wd_cnt_r;
  logic [CW-1:0]       wd_next_s;

  logic                core_enable_r;
  logic                core_rst_n_r;
  logic [WL-1:0]       core_xo_r;
  logic [WL-1:0]       core_yo_r;
  logic [WL-1:0]       core_zo_r;

  logic                rsp_valid_r;
  logic [IW-1:0]       rsp_id_r;
  logic [WL-1:0]       rsp_x_r;
  logic [WL-1:0]       rsp_y_r;
  logic [WL-1:0]       rsp_z_r;
  logic                rsp_timeout_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [IW-1:0]       grant_idx_s;
  logic                grant_any_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [WL-1:0]       op_x_s;
  logic [WL-1:0]       op_y_s;
  logic [WL-1:0]       op_z_s;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req      (req_valid),
    .last_ptr (last_ptr_r),
    .grant    (grant_s),
    .grant_idx(grant_idx_s),
    .grant_any(grant_any_s)
  );

  assign op_x_s    = req_x[int'(grant_idx_s) * WL +: WL];
  assign op_y_s    = req_y[int'(grant_idx_s) * WL +: WL];
  assign op_z_s    = req_z[int'(grant_idx_s) * WL +: WL];
  assign wd_next_s = wd_cnt_r + CW'(1);

  // Accept is only offered from IDLE, and never while reset is asserted.
  always_comb begin
    if ((state_r == IDLE) && !RST) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Scheduler FSM with all handshake, core and response outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= IDLE;
      last_ptr_r    <= IW'(NUM_REQ - 1);
      id_r          <= '0;
      wd_cnt_r      <= '0;
      core_enable_r <= 1'b0;
      core_rst_n_r  <= 1'b0;
      core_xo_r     <= '0;
      core_yo_r     <= '0;
      core_zo_r     <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_id_r      <= '0;
      rsp_x_r       <= '0;
      rsp_y_r       <= '0;
      rsp_z_r       <= '0;
      rsp_timeout_r <= 1'b0;
    end else begin
      core_enable_r <= 1'b0;
      core_rst_n_r  <= 1'b1;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            id_r          <= grant_idx_s;
            core_xo_r     <= op_x_s;
            core_yo_r     <= op_y_s;
            core_zo_r     <= op_z_s;
            core_enable_r <= 1'b1;
            state_r       <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt_r <= '0;
          state_r  <= BUSY;
        end
        BUSY: begin
          wd_cnt_r <= wd_next_s;
          // A done on the last watchdog cycle still counts as a good result.
          if (core_done) begin
            rsp_x_r       <= core_xn;
            rsp_y_r       <= core_yn;
            rsp_z_r       <= core_zn;
            rsp_timeout_r <= 1'b0;
            rsp_id_r      <= id_r;
            rsp_valid_r   <= 1'b1;
            state_r       <= RESP;
          end else if (wd_next_s == WD_LAST) begin
            core_rst_n_r <= 1'b0;
            state_r      <= ABORT;
          end
        end
        ABORT: begin
          rsp_x_r       <= '0;
          rsp_y_r       <= '0;
          rsp_z_r       <= '0;
          rsp_timeout_r <= 1'b1;
          rsp_id_r      <= id_r;
          rsp_valid_r   <= 1'b1;
          state_r       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            last_ptr_r  <= rsp_id_r;
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_id      = rsp_id_r;
  assign rsp_x       = rsp_x_r;
  assign rsp_y       = rsp_y_r;
  assign rsp_z       = rsp_z_r;
  assign rsp_timeout = rsp_timeout_r;
  assign core_enable = core_enable_r;
  assign core_xo     = core_xo_r;
  assign core_yo     = core_yo_r;
  assign core_zo     = core_zo_r;
  assign core_rst_n  = core_rst_n_r;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler with a behavioural core model whose
// done latency and done enable are set per scenario.
module tb_cordic_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WL      = 17;
  localparam int TIMEOUT = 32;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*WL-1:0] req_x = '0;
  logic [NUM_REQ*WL-1:0] req_y = '0;
  logic [NUM_REQ*WL-1:0] req_z = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [WL-1:0]         rsp_x, rsp_y, rsp_z;
  logic                  rsp_timeout;
  logic                  core_enable;
  logic [WL-1:0]         core_xo, core_yo, core_zo;
  logic [WL-1:0]         core_xn = '0;
  logic [WL-1:0]         core_yn = '0;
  logic [WL-1:0]         core_zn = '0;
  logic                  core_done = 1'b0;
  logic                  core_rst_n;

  int total = 0;
  int bad   = 0;
  int done_lat = 13;
  bit done_en  = 1'b1;
  int mdl_cnt  = 0;
  int en_cnt   = 0;

  always #5 CLK = ~CLK;

  cordic_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .INT_LENGTH(5), .FRAC_LENGTH(12), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_timeout(rsp_timeout),
    .core_enable(core_enable),
    .core_xo(core_xo), .core_yo(core_yo), .core_zo(core_zo),
    .core_xn(core_xn), .core_yn(core_yn), .core_zn(core_zn),
    .core_done(core_done), .core_rst_n(core_rst_n)
  );

  // Core model: done pulse done_lat cycles after the enable cycle.
  // Result transform: xn = xo + 0x100, yn = yo ^ zo, zn = ~zo.
  always @(negedge CLK) begin
    core_done = 1'b0;
    if (core_enable) en_cnt++;
    if (RST || !core_rst_n) begin
      mdl_cnt = 0;
    end else if (core_enable) begin
      mdl_cnt = done_lat;
    end else if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0 && done_en) begin
        core_done = 1'b1;
        core_xn   = core_xo + 17'h00100;
        core_yn   = core_yo ^ core_zo;
        core_zn   = ~core_zo;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [WL-1:0] x, input logic [WL-1:0] y,
                         input logic [WL-1:0] z);
    req_x[i*WL +: WL] = x;
    req_y[i*WL +: WL] = y;
    req_z[i*WL +: WL] = z;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick(); tick(); tick();
    total++;
    if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout} !== '0) begin
      bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout});
    end
    total++;
    if ({core_enable, core_xo, core_yo, core_zo, req_ready} !== '0) begin
      bad++; $display("FAIL reset_core got=%h exp=0", {core_enable, core_xo, core_yo, core_zo, req_ready});
    end
    total++;
    if (core_rst_n !== 1'b0) begin
      bad++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n);
    end
    RST = 1'b0;
    tick();
    total++;
    if (core_rst_n !== 1'b1) begin
      bad++; $display("FAIL reset_release got=%b exp=1", core_rst_n);
    end
  endtask

  task automatic test_single;
    int n;
    done_en = 1'b1; done_lat = 13;
    set_ops(1, 17'h009b7, 17'h00000, 17'h00c90);
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL single_grant got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    total++;
    if (core_enable !== 1'b1) begin
      bad++; $display("FAIL single_launch got=%b exp=1", core_enable);
    end
    total++;
    if ({core_xo, core_yo, core_zo} !== {17'h009b7, 17'h00000, 17'h00c90}) begin
      bad++; $display("FAIL single_operands got=%h %h %h exp=009b7 00000 00c90", core_xo, core_yo, core_zo);
    end
    tick();
    total++;
    if (core_enable !== 1'b0) begin
      bad++; $display("FAIL single_enable_pulse got=%b exp=0", core_enable);
    end
    wait_rsp(n);
    n = n + 2;
    total++;
    if (n != 15) begin
      bad++; $display("FAIL single_latency got=%0d exp=15", n);
    end
    total++;
    if ({rsp_id, rsp_timeout} !== {2'd1, 1'b0}) begin
      bad++; $display("FAIL single_id_to got=%0d %b exp=1 0", rsp_id, rsp_timeout);
    end
    total++;
    if ({rsp_x, rsp_y, rsp_z} !== {17'h00ab7, 17'h00c90, 17'h1f36f}) begin
      bad++; $display("FAIL single_data got=%h %h %h exp=00ab7 00c90 1f36f", rsp_x, rsp_y, rsp_z);
    end
    consume();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    int n;
    int base;
    logic [3:0] exp_g;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    done_en = 1'b1; done_lat = 13;
    rsp_ready = 1'b1;
    base = en_cnt;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 17'(i + 1), 17'(i + 2), 17'(i + 3));
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      n = 0;
      while (req_ready == 4'b0000 && n < 100) begin
        tick();
        n++;
      end
      total++;
      if (req_ready !== exp_g) begin
        bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, exp_g);
      end
      tick();
      if (k == 4) req_valid = 4'b0000;
    end
    wait_rsp(n);
    tick(); tick(); tick();
    rsp_ready = 1'b0;
    total++;
    if (en_cnt - base != 5) begin
      bad++; $display("FAIL rr_enable_count got=%0d exp=5", en_cnt - base);
    end
  endtask

  task automatic test_stall;
    int n;
    set_ops(2, 17'h00100, 17'h00200, 17'h00300);
    set_ops(3, 17'h01000, 17'h00010, 17'h00001);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1000;
    wait_rsp(n);
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout} !==
          {1'b1, 2'd2, 17'h00200, 17'h00100, 17'h1fcff, 1'b0}) begin
        bad++; $display("FAIL stall_hold_%0d got=%b %0d %h %h %h %b exp=1 2 00200 00100 1fcff 0",
                        c, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout);
      end
      total++;
      if (req_ready !== 4'b0000) begin
        bad++; $display("FAIL stall_no_ready_%0d got=%b exp=0000", c, req_ready);
      end
      tick();
    end
    consume();
    total++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin
      bad++; $display("FAIL stall_next_ready got=%b %b exp=0 1000", rsp_valid, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    wait_rsp(n);
    total++;
    if ({rsp_id, rsp_x, rsp_y, rsp_z} !== {2'd3, 17'h01100, 17'h00011, 17'h1fffe}) begin
      bad++; $display("FAIL stall_second got=%0d %h %h %h exp=3 01100 00011 1fffe", rsp_id, rsp_x, rsp_y, rsp_z);
    end
    consume();
  endtask

  task automatic run_watch(output int n, output int low_cnt, output int low_at);
    n = 1; low_cnt = 0; low_at = -1;
    while (!rsp_valid && n < 100) begin
      if (!core_rst_n) begin
        low_cnt++;
        low_at = n;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_timeout;
    int n, low_cnt, low_at;
    done_en = 1'b0;
    set_ops(1, 17'h00abc, 17'h00def, 17'h00123);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    run_watch(n, low_cnt, low_at);
    total++;
    if (n != TIMEOUT + 2) begin
      bad++; $display("FAIL timeout_rsp_cycle got=%0d exp=%0d", n, TIMEOUT + 2);
    end
    total++;
    if (low_cnt != 1 || low_at != TIMEOUT + 1) begin
      bad++; $display("FAIL timeout_core_rst got=%0d@%0d exp=1@%0d", low_cnt, low_at, TIMEOUT + 1);
    end
    total++;
    if ({rsp_id, rsp_timeout, rsp_x, rsp_y, rsp_z} !== {2'd1, 1'b1, 51'd0}) begin
      bad++; $display("FAIL timeout_rsp got=%0d %b %h %h %h exp=1 1 0 0 0", rsp_id, rsp_timeout, rsp_x, rsp_y, rsp_z);
    end
    consume();
    done_en = 1'b1;
  endtask

  task automatic test_coincident;
    int n, low_cnt, low_at;
    done_en = 1'b1; done_lat = TIMEOUT - 1;
    set_ops(0, 17'h00001, 17'h00002, 17'h00004);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    run_watch(n, low_cnt, low_at);
    total++;
    if (n != TIMEOUT + 1) begin
      bad++; $display("FAIL coinc_rsp_cycle got=%0d exp=%0d", n, TIMEOUT + 1);
    end
    total++;
    if (low_cnt != 0) begin
      bad++; $display("FAIL coinc_core_rst got=%0d exp=0", low_cnt);
    end
    total++;
    if ({rsp_id, rsp_timeout, rsp_x, rsp_y, rsp_z} !== {2'd0, 1'b0, 17'h00101, 17'h00006, 17'h1fffb}) begin
      bad++; $display("FAIL coinc_rsp got=%0d %b %h %h %h exp=0 0 00101 00006 1fffb", rsp_id, rsp_timeout, rsp_x, rsp_y, rsp_z);
    end
    consume();
    done_lat = 13;
  endtask

  task automatic test_reset_busy;
    int n;
    int seen;
    set_ops(2, 17'h00555, 17'h00666, 17'h00777);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) tick();
    RST = 1'b1;
    tick(); tick();
    total++;
    if ({rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout, core_enable, core_xo, core_yo, core_zo, req_ready} !== '0) begin
      bad++; $display("FAIL rstbusy_outputs got=%h exp=0",
                      {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z, rsp_timeout, core_enable, core_xo, core_yo, core_zo});
    end
    total++;
    if (core_rst_n !== 1'b0) begin
      bad++; $display("FAIL rstbusy_core_rst got=%b exp=0", core_rst_n);
    end
    RST = 1'b0;
    tick();
    total++;
    if (core_rst_n !== 1'b1) begin
      bad++; $display("FAIL rstbusy_release got=%b exp=1", core_rst_n);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rstbusy_no_rsp got=%0d exp=0", seen);
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL rstbusy_next_grant got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    wait_rsp(n);
    total++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL rstbusy_rsp_id got=%0d v=%b exp=0 v=1", rsp_id, rsp_valid);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_timeout();
    test_coincident();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
